// File: rtl/cordic_result_buffer.sv
// Result buffer behind the CORDIC pipeline: tags live pipeline slots, applies the quadrant
// signs to the float32 cos/sin magnitudes, and queues them behind credit-based admission.
module cordic_result_buffer #(
    parameter int LATENCY = 17,
    parameter int DEPTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic        cos_neg_in,
    input  logic        sin_neg_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] cos_out,
    output logic [31:0] sin_out,
    output logic [6:0]  count
);
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    logic [LATENCY-1:0] tag;
    logic [6:0]         credits;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        mem_cos [DEPTH];
    logic [31:0]        mem_sin [DEPTH];
    logic               issue;
    logic               pop;
    logic               res_valid;
    logic [31:0]        cos_signed;
    logic [31:0]        sin_signed;

    // Zero magnitude always leaves as +0, whatever the quadrant flag says.
    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return (v[30:0] == 31'd0) ? 32'd0 : {v[31] ^ neg, v[30:0]};
    endfunction

    assign issue      = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign res_valid  = tag[LATENCY-1];
    assign cos_signed = apply_sign(x_in, cos_neg_in);
    assign sin_signed = apply_sign(y_in, sin_neg_in);

    assign in_ready  = credits < DEPTH_C;
    assign out_valid = count != 7'd0;
    assign cos_out   = out_valid ? mem_cos[rd_ptr] : 32'd0;
    assign sin_out   = out_valid ? mem_sin[rd_ptr] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag     <= '0;
            credits <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            tag <= (tag << 1) | LATENCY'(issue);

            // An arrival only moves a credit from in-flight to buffered.
            case ({issue, pop})
                2'b10:   credits <= credits + 7'd1;
                2'b01:   credits <= credits - 7'd1;
                default: credits <= credits;
            endcase

            case ({res_valid, pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase

            if (res_valid) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (res_valid) begin
            mem_cos[wr_ptr] <= cos_signed;
            mem_sin[wr_ptr] <= sin_signed;
        end
    end

endmodule
